// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch unit.
//
// Requests one instruction word from instruction memory at PC_now, holds it
// in the inst register until downstream consumes it, then advances the PC to
// the externally computed PC_next. A consumed instruction with op_code 4'b0000
// stops fetching until reset.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   PC_next        next-PC value, loaded when inst is consumed
//   PC_now         current PC register
//   imem_req       fetch request (REQ state only)
//   imem_addr      fetch address, equal to PC_now
//   imem_gnt       memory accepted the request
//   imem_rvalid    imem_rdata valid this cycle
//   imem_rdata     returned instruction word
//   inst           held instruction register
//   inst_valid     inst awaiting consumption (HOLD state only)
//   inst_ready     downstream consumes inst this cycle
//   op_code        inst[IW-1:IW-4]
//   inst_addr      inst[7:0]
//   halted         fetch stopped on halt opcode
//   retire_cnt     wrapping count of consumed instructions
module inst_fetch #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned IW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    PC_next,
  output logic [7:0]    PC_now,
  output logic          imem_req,
  output logic [7:0]    imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] inst,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [3:0]    op_code,
  output logic [7:0]    inst_addr,
  output logic          halted,
  output logic [7:0]    retire_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } state_t;

  state_t state, state_nxt;
  logic   capture;
  logic   consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      PC_now     <= RESET_PC;
      inst       <= '0;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        inst <= imem_rdata;
      end
      if (consume) begin
        PC_now     <= PC_next;
        retire_cnt <= retire_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    halted     = 1'b0;
    capture    = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // rvalid is only meaningful here; stale responses elsewhere are dropped
        if (imem_rvalid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          consume   = 1'b1;
          state_nxt = (op_code == 4'b0000) ? HALT : REQ;
        end
      end
      HALT: halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_addr = PC_now;
  assign op_code   = inst[IW-1 -: 4];
  assign inst_addr = inst[7:0];

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter IW, default 16: instruction width; op_code = inst[IW-1:IW-4], inst_addr = inst[7:0].
REQ-003 clk  in  1  single clock for the block; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 PC_next  in  8  next-PC value computed combinationally from PC_now, op_code, inst_addr and ALU.
REQ-006 PC_now  out  8  current PC register.
REQ-007 imem_req  out  1  fetch request to instruction memory.
REQ-008 imem_addr  out  8  fetch address; equals PC_now.
REQ-009 imem_gnt  in  1  memory accepts request this cycle.
REQ-010 imem_rvalid  in  1  imem_rdata valid this cycle.
REQ-011 imem_rdata  in  IW  returned instruction word.
REQ-012 inst  out  IW  held instruction register.
REQ-013 inst_valid  out  1  inst holds an instruction awaiting consumption.
REQ-014 inst_ready  in  1  downstream consumes inst this cycle.
REQ-015 op_code  out  4  inst[IW-1:IW-4].
REQ-016 inst_addr  out  8  inst[7:0].
REQ-017 halted  out  1  fetch stopped on halt opcode.
REQ-018 retire_cnt  out  8  count of consumed instructions.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, HOLD, HALT.
REQ-020 IDLE SHALL go to REQ on the first clock edge after rst_n deasserts; all outputs idle.
REQ-021 REQ: imem_req=1 and imem_addr=PC_now; on imem_gnt=1 the FSM SHALL go to WAIT, otherwise stay in REQ with PC_now stable.
REQ-022 WAIT: imem_req=0; on imem_rvalid=1, imem_rdata SHALL be captured into inst and the FSM SHALL go to HOLD.
REQ-023 imem_rvalid outside WAIT SHALL be ignored; imem_gnt outside REQ SHALL be ignored.
REQ-024 HOLD: inst_valid=1 and inst stable until inst_ready=1.
REQ-025 On HOLD with inst_ready=1: PC_now <= PC_next and retire_cnt increments by 1.
REQ-026 On that same edge, op_code==4'b0000 SHALL go to HALT; any other op_code SHALL go to REQ.
REQ-027 Fetch-to-valid latency SHALL be: edge on which REQ sees gnt, then at least one WAIT cycle, then inst_valid on the cycle after rvalid; minimum of 2 cycles from gnt to inst_valid.
REQ-028 HALT: imem_req=0, inst_valid=0, halted=1, PC_now and retire_cnt frozen; HALT exits only through reset.
REQ-029 PC_now SHALL load PC_next unmodified, so 8'hFF+1 wraps to 8'h00.
REQ-030 retire_cnt SHALL wrap from 8'hFF to 8'h00.
REQ-031 inst_valid SHALL be 1 only in HOLD; imem_req SHALL be 1 only in REQ.
REQ-032 op_code and inst_addr SHALL be combinational slices of the inst register.

Reset
REQ-033 When rst_n=0, regardless of clk: state=IDLE, PC_now=RESET_PC, inst=0, inst_valid=0, imem_req=0, halted=0, retire_cnt=0.
REQ-034 Reset asserted in WAIT or HOLD SHALL discard the pending or held instruction; a later imem_rvalid for it SHALL be ignored, because the FSM is no longer in WAIT.
REQ-035 Deassertion SHALL be followed by exactly one IDLE cycle before the first imem_req.

Verification
REQ-036 Reset release with imem_gnt tied to 1 and rvalid one cycle after gnt -> imem_req=1 with imem_addr=8'h00 on the 2nd cycle, and inst_valid=1 two cycles after gnt.
REQ-037 Hold imem_gnt=0 for 5 cycles in REQ -> imem_req held high, PC_now=8'h00, no state change.
REQ-038 HOLD with inst op_code=4'b0101, inst_ready=1, PC_next=8'h3A -> PC_now=8'h3A, next imem_addr=8'h3A, retire_cnt=1.
REQ-039 HOLD with op_code=4'b0000 and inst_ready=1 -> halted=1, imem_req stays 0 for 20 cycles, and PC_now is unchanged.
REQ-040 PC_now=8'hFF and PC_next=8'h00 on consume -> next fetch address 8'h00; after 256 retires, retire_cnt returns to 8'h00.
REQ-041 Assert rst_n=0 mid-WAIT, release, then pulse a stale imem_rvalid during IDLE -> inst_valid stays 0 and PC_now=RESET_PC.
